// File: rtl/sra_unit.sv
// ---------------------------------------------------------------------------
// sra_unit -- registered arithmetic-right-shift unit for the 16-bit datapath.
//
// Shifts operand A right by Shamt positions, filling vacated MSBs with A's
// sign bit. The shift uses a log2 barrel shifter with stages of 1, 2, 4, 8, ...
// positions, each stage selected by one Shamt bit. The result and status
// flags are registered, so they appear one cycle after in_valid is sampled.
// There is no back-pressure, so a new operation can be accepted every cycle.
//
// Optional feature macro: SRA_STICKY_EN
//   defined   : sticky = OR of every bit shifted out, registered with the flags
//   undefined : sticky is tied to 0 and no sticky logic is built
//
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        A/Shamt valid this cycle
//   A          in   WIDTH    operand (two's complement)
//   Shamt      in   SHAMT_W  shift amount 0..WIDTH-1
//   out_valid  out  1        result/flags valid
//   ShiftedRA  out  WIDTH    A >>> Shamt
//   carry      out  1        last bit shifted out (0 when Shamt = 0)
//   zero       out  1        ShiftedRA == 0
//   neg        out  1        ShiftedRA[WIDTH-1]
//   sticky     out  1        OR of all bits shifted out
// ---------------------------------------------------------------------------
module sra_unit #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4    // must equal $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic               out_valid,
    output logic [WIDTH-1:0]   ShiftedRA,
    output logic               carry,
    output logic               zero,
    output logic               neg,
    output logic               sticky
);

    // Stage s holds the operand after the first s shift stages.
    logic [SHAMT_W:0][WIDTH-1:0] stage;
    // Last bit shifted out so far. Stages are applied in ascending order,
    // so the bit dropped by the last active stage is A[Shamt-1].
    logic [SHAMT_W:0]            stage_carry;
`ifdef SRA_STICKY_EN
    logic [SHAMT_W:0]            stage_sticky;
`endif

    assign stage[0]       = A;
    assign stage_carry[0] = 1'b0;
`ifdef SRA_STICKY_EN
    assign stage_sticky[0] = 1'b0;
`endif

    for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
        localparam int K = 1 << s;

        assign stage[s+1] = Shamt[s] ? {{K{A[WIDTH-1]}}, stage[s][WIDTH-1:K]}
                                     : stage[s];
        assign stage_carry[s+1] = Shamt[s] ? stage[s][K-1] : stage_carry[s];
`ifdef SRA_STICKY_EN
        assign stage_sticky[s+1] = Shamt[s] ? (stage_sticky[s] | (|stage[s][K-1:0]))
                                            : stage_sticky[s];
`endif
    end

    // Next-state values of the registered outputs.
    logic [WIDTH-1:0] result_d;
    logic             carry_d;
    logic             zero_d;
    logic             neg_d;

    assign result_d = stage[SHAMT_W];
    assign carry_d  = stage_carry[SHAMT_W];
    assign zero_d   = (result_d == '0);   // flags come from the shifted result
    assign neg_d    = result_d[WIDTH-1];

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             zero_q;
    logic             neg_q;

    // NOTE: state registers use non-blocking assignments so every register
    // samples its pre-edge inputs; blocking here would create order races.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            // Result and flags hold their last values while idle.
            if (in_valid) begin
                result_q <= result_d;
                carry_q  <= carry_d;
                zero_q   <= zero_d;
                neg_q    <= neg_d;
            end
        end
    end

`ifdef SRA_STICKY_EN
    logic sticky_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (in_valid) begin
            sticky_q <= stage_sticky[SHAMT_W];
        end
    end

    assign sticky = sticky_q;
`else
    assign sticky = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign ShiftedRA = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_sra_unit.sv
// ---------------------------------------------------------------------------
// tb_sra_unit -- directed self-checking bench for sra_unit.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each step() shows the result of the operation it launched.
// ---------------------------------------------------------------------------
module tb_sra_unit;
    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [WIDTH-1:0]   A;
    logic [SHAMT_W-1:0] Shamt;
    logic               out_valid;
    logic [WIDTH-1:0]   ShiftedRA;
    logic               carry;
    logic               zero;
    logic               neg;
    logic               sticky;

    int vectors     = 0;
    int miscompares = 0;

    sra_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .Shamt     (Shamt),
        .out_valid (out_valid),
        .ShiftedRA (ShiftedRA),
        .carry     (carry),
        .zero      (zero),
        .neg       (neg),
        .sticky    (sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then move to 1 unit past the next rising edge.
    task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] a,
                        input logic [SHAMT_W-1:0] s);
        rst      = r;
        in_valid = v;
        A        = a;
        Shamt    = s;
        @(posedge clk);
        #1;
    endtask

    // The sticky output only carries information when the feature is built.
    function automatic logic sticky_exp(input logic v);
`ifdef SRA_STICKY_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_result(input string tag, input logic [WIDTH-1:0] res,
                                input logic c, input logic z, input logic n,
                                input logic st);
        check({tag, ".valid"},  32'(out_valid), 32'd1);
        check({tag, ".result"}, 32'(ShiftedRA), 32'(res));
        check({tag, ".carry"},  32'(carry),     32'(c));
        check({tag, ".zero"},   32'(zero),      32'(z));
        check({tag, ".neg"},    32'(neg),       32'(n));
        check({tag, ".sticky"}, 32'(sticky),    32'(sticky_exp(st)));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".valid"},  32'(out_valid), 32'd0);
        check({tag, ".result"}, 32'(ShiftedRA), 32'd0);
        check({tag, ".carry"},  32'(carry),     32'd0);
        check({tag, ".zero"},   32'(zero),      32'd0);
        check({tag, ".neg"},    32'(neg),       32'd0);
        check({tag, ".sticky"}, 32'(sticky),    32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] exp_res;
        logic             exp_c;
        logic             exp_st;

        // Reset state.
        step(1'b1, 1'b0, 16'h0000, 4'd0);
        step(1'b1, 1'b0, 16'h0000, 4'd0);
        check_cleared("reset");

        // Directed vectors with hand-computed results.
        step(1'b0, 1'b1, 16'hC200, 4'd2);
        check_result("c200_sh2", 16'hF080, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h7FFF, 4'd15);
        check_result("7fff_sh15", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h8000, 4'd15);
        check_result("8000_sh15", 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h1234, 4'd0);
        check_result("1234_sh0", 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'hFFFF, 4'd0);
        check_result("ffff_sh0", 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back operations give results in consecutive cycles.
        step(1'b0, 1'b1, 16'h0010, 4'd4);
        check_result("b2b_first", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h8001, 4'd1);
        check_result("b2b_second", 16'hC000, 1'b1, 1'b0, 1'b1, 1'b1);

        // Idle: valid drops, result and flags hold.
        step(1'b0, 1'b0, 16'h0F0F, 4'd3);
        check("idle.valid",  32'(out_valid), 32'd0);
        check("idle.result", 32'(ShiftedRA), 32'hC000);
        check("idle.carry",  32'(carry),     32'd1);
        check("idle.neg",    32'(neg),       32'd1);

        // Reset wins over a simultaneous valid operation.
        step(1'b1, 1'b1, 16'hFFFF, 4'd5);
        check_cleared("rst_vs_valid");
        step(1'b0, 1'b0, 16'hFFFF, 4'd5);
        check("post_rst.valid",  32'(out_valid), 32'd0);
        check("post_rst.result", 32'(ShiftedRA), 32'd0);

        // Sweep every shift amount against a bit-level reference model.
        for (int s = 0; s < WIDTH; s++) begin
            for (int n = 0; n < 3; n++) begin
                a = (n == 0) ? 16'hA5C3 : WIDTH'($urandom);
                exp_res = WIDTH'($signed(a) >>> s);
                exp_c   = (s == 0) ? 1'b0 : a[s-1];
                exp_st  = 1'b0;
                for (int i = 0; i < s; i++) exp_st |= a[i];
                step(1'b0, 1'b1, a, SHAMT_W'(s));
                check_result($sformatf("sweep_sh%0d_%0d", s, n), exp_res, exp_c,
                             exp_res == '0, exp_res[WIDTH-1], exp_st);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
